// File: rtl/display_bcd_seq.sv
// Sequential binary-to-BCD (double-dabble, one bit per clock) seven-segment display driver.
// Optional macro SIGNED_DISPLAY_EN: treat valor as two's complement and draw a leading minus.
module display_bcd_seq #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DIGITS         = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clkSaida,
  input  logic                  reset,
  input  logic                  out,
  input  logic [DATA_W-1:0]     valor,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   digitos,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(DATA_W);
  localparam logic [6:0] SegDash = 7'h40;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, w_load;
  logic [BcdW-1:0]   r_bcd, w_adj, w_bcd_nxt;
  logic [CntW-1:0]   r_cnt;
  logic              r_ovf, w_ovf_nxt, w_carry, w_last;
  logic [BcdW-1:0]   r_digitos;
  logic              r_overflow;
  logic              w_sign_ovf, w_neg;
  logic [DIGITS-1:0] w_blank;
  logic [7*DIGITS-1:0] w_hex;
  logic              w_run;

`ifdef SIGNED_DISPLAY_EN
  logic r_sign, r_neg;
  // Magnitude; -2^(DATA_W-1) wraps to itself, which reads correctly as unsigned.
  assign w_load     = valor[DATA_W-1] ? (~valor + DATA_W'(1)) : valor;
  assign w_sign_ovf = r_sign && (w_bcd_nxt[BcdW-1 -: 4] != 4'd0);
  assign w_neg      = r_neg;
`else
  assign w_load     = valor;
  assign w_sign_ovf = 1'b0;
  assign w_neg      = 1'b0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clkSaida) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  assign w_last = (r_cnt == CntW'(1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (out) w_state_nxt = StShift;
      StShift: if (w_last) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  assign w_carry     = w_adj[BcdW-1];
  assign w_bcd_nxt   = {w_adj[BcdW-2:0], r_shift[DATA_W-1]};
  assign w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
  assign w_ovf_nxt   = r_ovf | w_carry;

  // Results are committed on the edge entering StDone so they are valid while done is high.
  always_ff @(posedge clkSaida) begin
    if (reset) begin
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_digitos  <= '0;
      r_overflow <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
      r_sign     <= 1'b0;
      r_neg      <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (out) begin
            r_shift <= w_load;
            r_bcd   <= '0;
            r_cnt   <= CntInit;
            r_ovf   <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
            r_sign  <= valor[DATA_W-1];
`endif
          end
        end
        StShift: begin
          r_shift <= w_shift_nxt;
          r_bcd   <= w_bcd_nxt;
          r_cnt   <= r_cnt - CntW'(1);
          r_ovf   <= w_ovf_nxt;
          if (w_last) begin
            r_digitos  <= w_bcd_nxt;
            r_overflow <= w_ovf_nxt | w_sign_ovf;
`ifdef SIGNED_DISPLAY_EN
            r_neg      <= r_sign && (w_bcd_nxt != '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_run   = 1'b1;
    w_blank = '0;
    w_hex   = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      w_run      = w_run && (r_digitos[4*k +: 4] == 4'd0);
      w_blank[k] = w_run && (k > 0);
    end
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_overflow)      w_hex[7*k +: 7] = SegDash;
      else if (w_blank[k]) w_hex[7*k +: 7] = 7'h00;
      else                 w_hex[7*k +: 7] = seg7(r_digitos[4*k +: 4]);
    end
    // Sign sits on the first blank display above the most significant digit.
    for (int k = 1; k < int'(DIGITS); k++) begin
      if (!r_overflow && w_neg && w_blank[k] && !w_blank[k-1]) w_hex[7*k +: 7] = SegDash;
    end
  end

  assign busy     = (r_state == StShift);
  assign done     = (r_state == StDone);
  assign overflow = r_overflow;
  assign digitos  = r_digitos;
  assign HEX      = SEG_ACTIVE_LOW ? ~w_hex : w_hex;

endmodule

// File: tb/tb_display_bcd_seq.sv
// Directed self-checking bench for display_bcd_seq with DATA_W=32, DIGITS=4, active-low segments.
module tb_display_bcd_seq;

  localparam int unsigned DataW  = 32;
  localparam int unsigned Digits = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        out = 1'b0;
  logic [31:0] valor = '0;
  logic        busy, done, overflow;
  logic [15:0] digitos;
  logic [27:0] hex;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_digits = '0;

  display_bcd_seq #(
    .DATA_W(DataW),
    .DIGITS(Digits),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clkSaida(clk),
    .reset(reset),
    .out(out),
    .valor(valor),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .digitos(digitos),
    .HEX(hex)
  );

  always #5 clk = ~clk;

  // Leaves the bench at the falling edge of cycle 1 (strobe sampled at edge 0).
  task automatic do_strobe(input logic [31:0] v);
    @(negedge clk);
    out = 1'b1;
    valor = v;
    @(negedge clk);
    out = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b ovf=%b, required 0 0 0", busy, done, overflow);
    end
    checks++;
    if (digitos !== 16'h0000) begin
      errors++;
      $display("FAIL reset_digitos: got %h, required 0000", digitos);
    end
    checks++;
    if (hex !== ~{7'h00, 7'h00, 7'h00, 7'h3F}) begin
      errors++;
      $display("FAIL reset_hex: got %h, required %h", hex, ~{7'h00, 7'h00, 7'h00, 7'h3F});
    end
    reset = 1'b0;
  endtask

  task automatic run_conv(input string name, input logic [31:0] v, input logic [15:0] exp_d,
                          input logic exp_o, input logic [27:0] exp_hex_ah);
    int bad_busy = 0;
    int done_at = -1;
    int done_n = 0;
    do_strobe(v);
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (busy !== (c <= 32)) bad_busy++;
      if (done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (c == 16) begin
        checks++;
        if (digitos !== prev_digits) begin
          errors++;
          $display("FAIL %s_hold: digitos=%h mid-conversion, required %h", name, digitos,
                   prev_digits);
        end
      end
      if (c == 33) begin
        checks++;
        if (digitos !== exp_d) begin
          errors++;
          $display("FAIL %s_digitos: got %h, required %h", name, digitos, exp_d);
        end
        checks++;
        if (overflow !== exp_o) begin
          errors++;
          $display("FAIL %s_overflow: got %b, required %b", name, overflow, exp_o);
        end
        checks++;
        if (hex !== ~exp_hex_ah) begin
          errors++;
          $display("FAIL %s_hex: got %h, required %h", name, hex, ~exp_hex_ah);
        end
      end
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL %s_busy: %0d cycles wrong, required busy exactly in cycles 1..32", name,
               bad_busy);
    end
    checks++;
    if (done_at != 33 || done_n != 1) begin
      errors++;
      $display("FAIL %s_done: first at cycle %0d, %0d pulses, required cycle 33, 1 pulse", name,
               done_at, done_n);
    end
    prev_digits = exp_d;
  endtask

  task automatic test_convert();
    run_conv("v1234", 32'd1234, 16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66});
  endtask

  task automatic test_blanking();
    run_conv("v0", 32'd0, 16'h0000, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F});
    run_conv("v7", 32'd7, 16'h0007, 1'b0, {7'h00, 7'h00, 7'h00, 7'h07});
  endtask

  task automatic test_overflow();
    run_conv("v10000", 32'd10000, 16'h0000, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40});
    run_conv("v9999", 32'd9999, 16'h9999, 1'b0, {7'h6F, 7'h6F, 7'h6F, 7'h6F});
  endtask

  task automatic test_back_to_back();
    int done_at = -1;
    int done_n = 0;
    int busy_n = 0;
    logic [15:0] d_at_done = '0;
    do_strobe(32'd42);
    for (int c = 1; c <= 80; c++) begin
      if (c > 1) @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          d_at_done = digitos;
        end
      end
      if (c == 4) begin
        out = 1'b1;
        valor = 32'd99;
      end
      if (c == 5) out = 1'b0;
    end
    checks++;
    if (done_n != 1 || done_at != 33) begin
      errors++;
      $display("FAIL b2b_done: %0d pulses first at %0d, required 1 pulse at 33", done_n, done_at);
    end
    checks++;
    if (d_at_done !== 16'h0042) begin
      errors++;
      $display("FAIL b2b_digitos: got %h, required 0042", d_at_done);
    end
    checks++;
    if (busy_n != 32) begin
      errors++;
      $display("FAIL b2b_busy: %0d busy cycles, required 32", busy_n);
    end
    prev_digits = 16'h0042;
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    do_strobe(32'd5678);
    for (int c = 2; c <= 9; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flags: busy=%b done=%b ovf=%b, required 0 0 0", busy, done, overflow);
    end
    checks++;
    if (digitos !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_digitos: got %h, required 0000", digitos);
    end
    checks++;
    if (hex !== ~{7'h00, 7'h00, 7'h00, 7'h3F}) begin
      errors++;
      $display("FAIL rstmid_hex: got %h, required %h", hex, ~{7'h00, 7'h00, 7'h00, 7'h3F});
    end
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_n++;
    end
    checks++;
    if (done_n != 0) begin
      errors++;
      $display("FAIL rstmid_no_done: %0d busy/done cycles after reset, required 0", done_n);
    end
    prev_digits = 16'h0000;
  endtask

`ifdef SIGNED_DISPLAY_EN
  task automatic test_signed();
    run_conv("neg42", 32'hFFFF_FFD6, 16'h0042, 1'b0, {7'h00, 7'h40, 7'h66, 7'h5B});
    run_conv("neg1234", 32'hFFFF_FB2E, 16'h1234, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40});
  endtask
`endif

  initial begin
    test_reset();
    test_convert();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef SIGNED_DISPLAY_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
